axi_write_arbiter: RTL and testbench
====================================

// Module: axi_write_arbiter
// PURPOSE
//  Shares one AXI3 slave write port (AW/W/B, e.g. the ILA slave-write model) between NUM_M masters.
//  Grants whole transactions, round-robin: an AW is forwarded, its W burst is routed until WLAST, then B returns to the owner.
//  Only one write is outstanding at a time; W and B routing follow the granted index.
//  Sits between the master-side interconnect and the single s_axi_* write slave.
// PARAMETERS
//  NUM_M   2   number of requesting masters (2..8)
//  ID_W    12  AWID/BID width
//  ADDR_W  32  AWADDR width
//  DATA_W  32  WDATA width; WSTRB is DATA_W/8
// PORTS
//  clk            in   1              clock, all logic posedge
//  s_axi_aresetn  in   1              asynchronous, active-low reset
//  m_awvalid      in   NUM_M          per-master AW request
//  m_awready      out  NUM_M          per-master AW accept
//  m_aw{addr,id,len,size,burst} in  NUM_M*{ADDR_W,ID_W,8,3,2}  packed per-master AW fields
//  m_wvalid/m_wlast in NUM_M;  m_wdata in NUM_M*DATA_W;  m_wstrb in NUM_M*DATA_W/8
//  m_wready       out  NUM_M          per-master W accept
//  m_bvalid       out  NUM_M          per-master B valid
//  m_bready       in   NUM_M          per-master B accept
//  m_bid/m_bresp  out  ID_W/2         shared B payload, meaningful only with the owner's m_bvalid
//  s_axi_aw*      out  as above       AW toward slave (valid,addr,id,len,size,burst); s_axi_awready in
//  s_axi_w*       out  as above       W toward slave (valid,data,strb,last); s_axi_wready in
//  s_axi_b*       in   1/ID_W/2       B from slave (bvalid,bid,bresp); s_axi_bready out
//  gnt_idx        out  $clog2(NUM_M)  current/last owner
//  busy           out  1              high outside IDLE
// BEHAVIOUR
//  States: IDLE -> AW -> W -> B -> IDLE.
//  Reset (async, any state): state=IDLE, gnt_idx=0, rr pointer=0.
//    All valid/ready outputs 0, bid/bresp 0.
//    An in-flight burst is abandoned; no partial handshakes are completed.
//  IDLE: if any m_awvalid, pick the first requester at or after (last_gnt+1) mod NUM_M.
//    Register it into gnt_idx and go to AW next cycle (1-cycle arbitration latency).
//  AW: s_axi_aw* = granted master's fields (combinational mux).
//    m_awready[gnt]=s_axi_awready; the other masters' awready=0.
//    On s_axi_awvalid&s_axi_awready: latch awlen into beat counter, go to W.
//  W: s_axi_w* muxed from gnt; m_wready[gnt]=s_axi_wready; the other masters' wready=0.
//    Each handshake decrements the beat counter (8-bit, no wrap below 0).
//    Handshake with wlast=1: go to B.
//  B: s_axi_bready=m_bready[gnt]; m_bvalid[gnt]=s_axi_bvalid; bid/bresp passed through.
//    On handshake: rr pointer=gnt, go to IDLE.
//  Masters that are not granted keep awvalid high and wait; there is no timeout.
//  A requester that drops awvalid before grant is simply skipped.
//  AW handshake and s_axi_wvalid in the same cycle: W is not forwarded until the W state (no W before AW).
//  Simultaneous B handshake and new AW requests: the new grant is taken in IDLE the following cycle.
// CONFIGURATION
//  ARB_BEAT_CHECK_EN defined:
//    wlast on a beat with counter!=0, or counter==0 beat without wlast, sets sticky output beat_err.
//    beat_err is cleared only by reset.
//    That transaction's bresp to the master is forced to 2'b10 (SLVERR).
//    If the last beat carries no wlast, the arbiter drives s_axi_wlast=1 and moves to B.
//  ARB_BEAT_CHECK_EN undefined: no beat_err port; wlast alone ends W; bresp passed through unmodified.
// STRUCTURE
//  Package axi_arb_pkg:
//    arb_state_e {IDLE,AW,W,B};
//    RESP_OKAY=2'b00, RESP_SLVERR=2'b10;
//    burst constants FIXED/INCR/WRAP.
//  Sub-module rr_pick: combinational round-robin picker.
//    Inputs: req[NUM_M], ptr. Outputs: any, idx.
//  All channel muxing stays inline in axi_write_arbiter.
// TESTING
//  1. Single master 0, awlen=3, INCR, slave always ready:
//     grant 1 cycle after awvalid, 4 W beats, B OKAY returned to m0 only; busy low after B.
//  2. m0 and m1 request together, last_gnt=0 after reset:
//     m1 granted first, m0 next; m0's awready stays 0 throughout m1's transaction.
//  3. Slave throttles wready 1-of-3 cycles, awlen=7:
//     exactly 8 handshakes, no data loss, m_wready mirrors s_axi_wready only for the owner.
//  4. m_bready held low 5 cycles: state stays B, s_axi_bready=0, no new grant despite pending m1 awvalid.
//  5. Reset asserted in the middle of the W phase:
//     all valids drop asynchronously, gnt_idx=0, IDLE.
//     A new request after reset release completes normally.
//  6. (ARB_BEAT_CHECK_EN) awlen=3 with wlast on beat 2: beat_err=1, m_bresp=2'b10, next transaction OKAY.

Source files
------------

// File: rtl/axi_arb_pkg.sv
// axi_arb_pkg: shared state type and AXI constants for axi_write_arbiter.
package axi_arb_pkg;
   typedef enum logic [1:0] {IDLE, AW, W, B} arb_state_e;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker; first requester at or after ptr+1 (mod N).
module rr_pick #(
   parameter int N = 2,
   parameter int W = 1
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic         any,
   output logic [W-1:0] idx
);
   int best;
   always_comb begin
      any  = |req;
      idx  = '0;
      best = N;
      for (int j = 0; j < N; j++) begin
         if (req[j] && ((j - int'(ptr) - 1 + 2 * N) % N) < best) begin
            best = (j - int'(ptr) - 1 + 2 * N) % N;
            idx  = W'(j);
         end
      end
   end
endmodule

// File: rtl/axi_write_arbiter.sv
// axi_write_arbiter: round-robin sharing of one AXI3 write slave by NUM_M masters, one whole
// transaction (AW, W burst, B) at a time. Define ARB_BEAT_CHECK_EN to add beat-count checking (beat_err).
module axi_write_arbiter
   import axi_arb_pkg::*;
#(
   parameter int NUM_M  = 2,
   parameter int ID_W   = 12,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                       clk,
   input  logic                       s_axi_aresetn,
   input  logic [NUM_M-1:0]           m_awvalid,
   output logic [NUM_M-1:0]           m_awready,
   input  logic [NUM_M*ADDR_W-1:0]    m_awaddr,
   input  logic [NUM_M*ID_W-1:0]      m_awid,
   input  logic [NUM_M*8-1:0]         m_awlen,
   input  logic [NUM_M*3-1:0]         m_awsize,
   input  logic [NUM_M*2-1:0]         m_awburst,
   input  logic [NUM_M-1:0]           m_wvalid,
   input  logic [NUM_M-1:0]           m_wlast,
   input  logic [NUM_M*DATA_W-1:0]    m_wdata,
   input  logic [NUM_M*DATA_W/8-1:0]  m_wstrb,
   output logic [NUM_M-1:0]           m_wready,
   output logic [NUM_M-1:0]           m_bvalid,
   input  logic [NUM_M-1:0]           m_bready,
   output logic [ID_W-1:0]            m_bid,
   output logic [1:0]                 m_bresp,
   output logic                       s_axi_awvalid,
   output logic [ADDR_W-1:0]          s_axi_awaddr,
   output logic [ID_W-1:0]            s_axi_awid,
   output logic [7:0]                 s_axi_awlen,
   output logic [2:0]                 s_axi_awsize,
   output logic [1:0]                 s_axi_awburst,
   input  logic                       s_axi_awready,
   output logic                       s_axi_wvalid,
   output logic [DATA_W-1:0]          s_axi_wdata,
   output logic [DATA_W/8-1:0]        s_axi_wstrb,
   output logic                       s_axi_wlast,
   input  logic                       s_axi_wready,
   input  logic                       s_axi_bvalid,
   input  logic [ID_W-1:0]            s_axi_bid,
   input  logic [1:0]                 s_axi_bresp,
   output logic                       s_axi_bready,
   output logic [$clog2(NUM_M)-1:0]   gnt_idx,
`ifdef ARB_BEAT_CHECK_EN
   output logic                       beat_err,
`endif
   output logic                       busy
);
   localparam int GW = $clog2(NUM_M);
   localparam int SW = DATA_W / 8;
   arb_state_e state, state_d;
   logic [7:0] cnt;
   logic [GW-1:0] ptr, pick;
   logic any, aw_hs, w_hs, b_hs, last_beat;
   logic [1:0] resp;

   rr_pick #(.N(NUM_M), .W(GW)) u_pick (.req(m_awvalid), .ptr(ptr), .any(any), .idx(pick));

   // handshakes are built from state and inputs only, so the output mux never feeds itself
   assign aw_hs = (state == AW) & m_awvalid[gnt_idx] & s_axi_awready;
   assign w_hs  = (state == W) & m_wvalid[gnt_idx] & s_axi_wready;
   assign b_hs  = (state == B) & s_axi_bvalid & m_bready[gnt_idx];
   assign busy  = state != IDLE;

`ifdef ARB_BEAT_CHECK_EN
   logic txn_err, beat_bad;
   // an exhausted counter closes the burst even when the master forgets wlast
   assign last_beat = m_wlast[gnt_idx] | (cnt == 8'd0);
   assign beat_bad  = w_hs & (m_wlast[gnt_idx] ^ (cnt == 8'd0));
   assign resp      = txn_err ? RESP_SLVERR : s_axi_bresp;
   always_ff @(posedge clk or negedge s_axi_aresetn)
      if (!s_axi_aresetn) begin
         txn_err  <= 1'b0;
         beat_err <= 1'b0;
      end else begin
         txn_err  <= aw_hs ? 1'b0 : txn_err | beat_bad;
         beat_err <= beat_err | beat_bad;
      end
`else
   assign last_beat = m_wlast[gnt_idx];
   assign resp      = s_axi_bresp;
`endif

   always_ff @(posedge clk or negedge s_axi_aresetn)
      if (!s_axi_aresetn) begin
         state   <= IDLE;
         gnt_idx <= '0;
         ptr     <= '0;
         cnt     <= '0;
      end else begin
         state   <= state_d;
         gnt_idx <= (state == IDLE && any) ? pick : gnt_idx;
         ptr     <= b_hs ? gnt_idx : ptr;
         cnt     <= aw_hs ? m_awlen[gnt_idx*8 +: 8] : (w_hs && cnt != 8'd0) ? cnt - 8'd1 : cnt;
      end

   always_comb begin
      state_d = (state == IDLE && any) ? AW :
                aw_hs                  ? W  :
                (w_hs && last_beat)    ? B  :
                b_hs                   ? IDLE : state;
      m_awready          = '0;
      m_wready           = '0;
      m_bvalid           = '0;
      m_awready[gnt_idx] = (state == AW) & s_axi_awready;
      m_wready[gnt_idx]  = (state == W) & s_axi_wready;
      m_bvalid[gnt_idx]  = (state == B) & s_axi_bvalid;
      s_axi_awvalid      = (state == AW) & m_awvalid[gnt_idx];
      s_axi_awaddr       = m_awaddr[gnt_idx*ADDR_W +: ADDR_W];
      s_axi_awid         = m_awid[gnt_idx*ID_W +: ID_W];
      s_axi_awlen        = m_awlen[gnt_idx*8 +: 8];
      s_axi_awsize       = m_awsize[gnt_idx*3 +: 3];
      s_axi_awburst      = m_awburst[gnt_idx*2 +: 2];
      s_axi_wvalid       = (state == W) & m_wvalid[gnt_idx];
      s_axi_wdata        = m_wdata[gnt_idx*DATA_W +: DATA_W];
      s_axi_wstrb        = m_wstrb[gnt_idx*SW +: SW];
      s_axi_wlast        = (state == W) & last_beat;
      s_axi_bready       = (state == B) & m_bready[gnt_idx];
      m_bid              = (state == B) ? s_axi_bid : '0;
      m_bresp            = (state == B) ? resp : 2'b00;
   end
endmodule

// File: tb/tb_axi_write_arbiter.sv
// tb_axi_write_arbiter: directed self-checking bench for axi_write_arbiter (NUM_M=2).
module tb_axi_write_arbiter;
   import axi_arb_pkg::*;
   localparam int NUM_M = 2, ID_W = 12, ADDR_W = 32, DATA_W = 32;
   logic clk = 1'b0, rstn = 1'b0;
   logic [NUM_M-1:0] m_awvalid, m_awready, m_wvalid, m_wlast, m_wready, m_bvalid, m_bready;
   logic [NUM_M*ADDR_W-1:0] m_awaddr;
   logic [NUM_M*ID_W-1:0] m_awid;
   logic [NUM_M*8-1:0] m_awlen;
   logic [NUM_M*3-1:0] m_awsize;
   logic [NUM_M*2-1:0] m_awburst;
   logic [NUM_M*DATA_W-1:0] m_wdata;
   logic [NUM_M*DATA_W/8-1:0] m_wstrb;
   logic [ID_W-1:0] m_bid, s_axi_awid, s_axi_bid;
   logic [1:0] m_bresp, s_axi_awburst, s_axi_bresp;
   logic s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wlast, s_axi_wready;
   logic s_axi_bvalid, s_axi_bready, busy;
   logic [ADDR_W-1:0] s_axi_awaddr;
   logic [7:0] s_axi_awlen;
   logic [2:0] s_axi_awsize;
   logic [DATA_W-1:0] s_axi_wdata;
   logic [DATA_W/8-1:0] s_axi_wstrb;
   logic [0:0] gnt_idx;
`ifdef ARB_BEAT_CHECK_EN
   logic beat_err;
`endif
   int n_tests = 0, n_fail = 0, beat;

   axi_write_arbiter #(.NUM_M(NUM_M), .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk(clk), .s_axi_aresetn(rstn),
      .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awid(m_awid),
      .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
      .m_wvalid(m_wvalid), .m_wlast(m_wlast), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wready(m_wready),
      .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bid(m_bid), .m_bresp(m_bresp),
      .s_axi_awvalid(s_axi_awvalid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awid(s_axi_awid),
      .s_axi_awlen(s_axi_awlen), .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
      .s_axi_awready(s_axi_awready),
      .s_axi_wvalid(s_axi_wvalid), .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
      .s_axi_wlast(s_axi_wlast), .s_axi_wready(s_axi_wready),
      .s_axi_bvalid(s_axi_bvalid), .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp),
      .s_axi_bready(s_axi_bready), .gnt_idx(gnt_idx),
`ifdef ARB_BEAT_CHECK_EN
      .beat_err(beat_err),
`endif
      .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish before 200000");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      m_awvalid = '0; m_wvalid = '0; m_wlast = '0; m_bready = '0; m_wdata = '0;
      m_wstrb = '1;
      m_awaddr = {32'h0000_2000, 32'h0000_1000};
      m_awid = {12'h0B1, 12'h0A0};
      m_awlen = {8'd0, 8'd3};
      m_awsize = {3'd2, 3'd2};
      m_awburst = {BURST_INCR, BURST_INCR};
      s_axi_awready = 1'b1; s_axi_wready = 1'b1;
      s_axi_bvalid = 1'b0; s_axi_bid = '0; s_axi_bresp = RESP_OKAY;
      repeat (2) tick();
      rstn = 1'b1;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_gnt", gnt_idx, 0);
      chk("rst_awvalid", s_axi_awvalid, 0);
      chk("rst_bready", s_axi_bready, 0);
      chk("rst_bid", m_bid, 0);
`ifdef ARB_BEAT_CHECK_EN
      chk("rst_beat_err", beat_err, 0);
`endif
      // single master 0, four beats
      m_awvalid = 2'b01;
      #1 chk("t1_idle_awready", m_awready, 0);
      tick();
      chk("t1_gnt", gnt_idx, 0);
      chk("t1_busy", busy, 1);
      chk("t1_awvalid", s_axi_awvalid, 1);
      chk("t1_awaddr", s_axi_awaddr, 32'h1000);
      chk("t1_awid", s_axi_awid, 12'h0A0);
      chk("t1_awlen", s_axi_awlen, 3);
      chk("t1_awburst", s_axi_awburst, BURST_INCR);
      chk("t1_awready", m_awready, 2'b01);
      tick();
      m_awvalid = 2'b00; m_wvalid = 2'b01;
      for (int i = 0; i < 4; i++) begin
         m_wdata[31:0] = 32'hA000_0000 + i;
         m_wlast[0] = (i == 3);
         #1;
         chk("t1_wdata", s_axi_wdata, 32'hA000_0000 + i);
         chk("t1_wlast", s_axi_wlast, (i == 3));
         chk("t1_wready", m_wready, 2'b01);
         tick();
      end
      m_wvalid = 2'b00; m_wlast = 2'b00;
      s_axi_bvalid = 1'b1; s_axi_bid = 12'h0A0; s_axi_bresp = RESP_OKAY; m_bready = 2'b11;
      #1;
      chk("t1_w_done", s_axi_wvalid, 0);
      chk("t1_bvalid", m_bvalid, 2'b01);
      chk("t1_bid", m_bid, 12'h0A0);
      chk("t1_bresp", m_bresp, RESP_OKAY);
      chk("t1_bready", s_axi_bready, 1);
      tick();
      s_axi_bvalid = 1'b0; m_bready = 2'b00;
      #1;
      chk("t1_idle", busy, 0);
      chk("t1_bvalid_off", m_bvalid, 0);
      // both request: m1 first (last grant 0), then m0
      m_awvalid = 2'b11;
      tick();
      chk("t2_gnt_m1", gnt_idx, 1);
      chk("t2_awready", m_awready, 2'b10);
      chk("t2_awaddr", s_axi_awaddr, 32'h2000);
      m_wvalid = 2'b10; m_wlast = 2'b10; m_wdata[63:32] = 32'hB000_0000;
      #1 chk("t2_no_w_before_aw", s_axi_wvalid, 0);
      tick();
      m_awvalid = 2'b01;
      #1;
      chk("t2_wvalid", s_axi_wvalid, 1);
      chk("t2_wdata", s_axi_wdata, 32'hB000_0000);
      chk("t2_wready", m_wready, 2'b10);
      chk("t2_m0_awready_w", m_awready, 0);
      tick();
      m_wvalid = 2'b00; m_wlast = 2'b00;
      s_axi_bvalid = 1'b1; s_axi_bid = 12'h0B1; m_bready = 2'b11;
      #1;
      chk("t2_bvalid", m_bvalid, 2'b10);
      chk("t2_bid", m_bid, 12'h0B1);
      chk("t2_m0_awready_b", m_awready, 0);
      tick();
      s_axi_bvalid = 1'b0; m_bready = 2'b00;
      #1 chk("t2_idle", busy, 0);
      tick();
      chk("t2_gnt_m0", gnt_idx, 0);
      chk("t2_awready_m0", m_awready, 2'b01);
      // m0 eight beats against a slave ready one cycle in three
      m_awlen[7:0] = 8'd7;
      #1 chk("t3_awlen", s_axi_awlen, 7);
      tick();
      m_awvalid = 2'b00; m_wvalid = 2'b01;
      beat = 0;
      for (int c = 0; c < 40 && beat < 8; c++) begin
         s_axi_wready = (c % 3 == 0);
         m_wdata[31:0] = 32'hC000_0000 + beat;
         m_wlast[0] = (beat == 7);
         #1;
         chk("t3_wready_mirror", m_wready, {1'b0, s_axi_wready});
         if (s_axi_wvalid && s_axi_wready) begin
            chk("t3_wdata", s_axi_wdata, 32'hC000_0000 + beat);
            beat++;
         end
         tick();
      end
      chk("t3_beats", beat, 8);
      m_wvalid = 2'b00; m_wlast = 2'b00; s_axi_wready = 1'b1;
      // B held off by m_bready while m1 waits
      m_awvalid = 2'b10; s_axi_bvalid = 1'b1; s_axi_bid = 12'h0A0;
      for (int c = 0; c < 5; c++) begin
         #1;
         chk("t4_bready_low", s_axi_bready, 0);
         chk("t4_busy", busy, 1);
         chk("t4_bvalid", m_bvalid, 2'b01);
         chk("t4_gnt_hold", gnt_idx, 0);
         chk("t4_no_awready", m_awready, 0);
         tick();
      end
      m_bready = 2'b01;
      #1 chk("t4_bready_go", s_axi_bready, 1);
      tick();
      s_axi_bvalid = 1'b0; m_bready = 2'b00;
      #1 chk("t4_idle", busy, 0);
      tick();
      chk("t4_gnt_m1", gnt_idx, 1);
      // reset in the middle of m1's W phase
      m_awlen[15:8] = 8'd3;
      tick();
      m_awvalid = 2'b00; m_wvalid = 2'b10; m_wdata[63:32] = 32'hD000_0000;
      tick();
      chk("t5_in_w", s_axi_wvalid, 1);
      #2 rstn = 1'b0;
      #1;
      chk("t5_rst_wvalid", s_axi_wvalid, 0);
      chk("t5_rst_busy", busy, 0);
      chk("t5_rst_gnt", gnt_idx, 0);
      chk("t5_rst_wready", m_wready, 0);
      m_wvalid = 2'b00;
      tick();
      rstn = 1'b1;
      m_awvalid = 2'b01; m_awlen[7:0] = 8'd0;
      tick();
      chk("t5_gnt", gnt_idx, 0);
      chk("t5_awvalid", s_axi_awvalid, 1);
      tick();
      m_awvalid = 2'b00; m_wvalid = 2'b01; m_wlast = 2'b01; m_wdata[31:0] = 32'hE000_0000;
      #1 chk("t5_wdata", s_axi_wdata, 32'hE000_0000);
      tick();
      m_wvalid = 2'b00; m_wlast = 2'b00;
      s_axi_bvalid = 1'b1; s_axi_bresp = RESP_OKAY; m_bready = 2'b01;
      #1;
      chk("t5_bvalid", m_bvalid, 2'b01);
      chk("t5_bresp", m_bresp, RESP_OKAY);
      tick();
      s_axi_bvalid = 1'b0; m_bready = 2'b00;
      #1 chk("t5_idle", busy, 0);
`ifdef ARB_BEAT_CHECK_EN
      // early wlast on the third of four beats
      m_awvalid = 2'b01; m_awlen[7:0] = 8'd3;
      tick();
      tick();
      m_awvalid = 2'b00; m_wvalid = 2'b01;
      for (int i = 0; i < 3; i++) begin
         m_wlast[0] = (i == 2);
         tick();
      end
      m_wvalid = 2'b00; m_wlast = 2'b00;
      s_axi_bvalid = 1'b1; s_axi_bresp = RESP_OKAY; m_bready = 2'b01;
      #1;
      chk("t6_beat_err", beat_err, 1);
      chk("t6_slverr", m_bresp, RESP_SLVERR);
      tick();
      s_axi_bvalid = 1'b0; m_bready = 2'b00;
      m_awvalid = 2'b01; m_awlen[7:0] = 8'd0;
      tick();
      tick();
      m_awvalid = 2'b00; m_wvalid = 2'b01; m_wlast = 2'b01;
      tick();
      m_wvalid = 2'b00; m_wlast = 2'b00;
      s_axi_bvalid = 1'b1; m_bready = 2'b01;
      #1;
      chk("t6_next_okay", m_bresp, RESP_OKAY);
      chk("t6_sticky", beat_err, 1);
      tick();
      s_axi_bvalid = 1'b0; m_bready = 2'b00;
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
